muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for the HI/LO multiply/divide resource beside the ALU.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_step.sv | 56 +++++
 rtl/muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared definitions for the HI/LO multiply/divide sequencer.
//            - MD_* opcodes issued by the execute stage
//            - FSM state encoding used by muldiv_ctrl
// Ports    : none (package)
// Config   : MULDIV_DIV_EN (consumed by muldiv_ctrl / muldiv_step)
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MFHI  = 3'b100;
  localparam logic [2:0] MD_MFLO  = 3'b101;
  localparam logic [2:0] MD_MTHI  = 3'b110;
  localparam logic [2:0] MD_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Purpose  : Request/response bundle between the execute stage (master) and
//            the multiply/divide sequencer (slave).
// Ports    : start, op[2:0], a, b, flush   (master -> slave)
//            busy, done, result            (slave  -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, flush, input busy, done, result);
  modport slave  (input start, op, a, b, flush, output busy, done, result);
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational iteration of the HI/LO engine.
//            mode=0 : add-shift multiply (acc_lo holds the multiplier, the
//                     product shifts in from the top of acc_hi)
//            mode=1 : restoring shift-subtract divide (acc_hi is the partial
//                     remainder, acc_lo shifts dividend out / quotient in)
// Ports    : acc_hi, acc_lo, operand, mode -> next_hi, next_lo
// Config   : MULDIV_DIV_EN undefined removes the divide datapath.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  input  logic             mode,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  // Carry out of the add is kept so the shifted product never loses a bit.
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH + 1){1'b0}});

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  // Partial remainder shifted left with the next dividend bit; it is one bit
  // wider than the divisor, so the compare runs at WIDTH+1 bits. When it
  // succeeds the difference is below the divisor and fits in WIDTH bits.
  assign w_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, operand});
  assign w_sub   = w_shift[WIDTH-1:0] - operand;

  always_comb begin
    next_hi = w_sum[WIDTH:1];
    next_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
    if (mode) begin
      next_hi = w_ge ? w_sub : w_shift[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], w_ge};
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign next_hi = w_sum[WIDTH:1];
  assign next_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : Multi-cycle sequencer for the HI/LO multiply/divide resource.
//            IDLE -> MUL|DIV (WIDTH iterations) -> FIX (sign fix + commit).
//            Owns HI/LO, stalls the pipeline through busy, pulses done on the
//            final busy cycle.
// Ports    : clk, rst (async, active-high)
//            md (muldiv_if.slave): start, op, a, b, flush -> busy, done, result
// Config   : MULDIV_DIV_EN defined   -> div/divu executed
//            MULDIV_DIV_EN undefined -> div/divu accepted as no-ops
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave md
);

  localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_operand;
  logic               r_neg;      // negate product / quotient in FIX
`ifdef MULDIV_DIV_EN
  logic               r_is_div;
  logic               r_neg_rem;  // remainder follows the dividend sign
  logic               w_is_div;
`endif

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic               w_busy;
  logic               w_done;
  logic               w_iter;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [2*WIDTH-1:0] w_prod;

  // Flush in the same cycle as start kills the request, mt* included.
  assign w_accept    = (r_state == IDLE) && md.start && !md.flush;
  assign w_is_mul    = (md.op == MD_MULT) || (md.op == MD_MULTU);
  assign w_is_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign w_sign_a    = w_is_signed && md.a[WIDTH-1];
  assign w_sign_b    = w_is_signed && md.b[WIDTH-1];
  assign w_abs_a     = w_sign_a ? -md.a : md.a;
  assign w_abs_b     = w_sign_b ? -md.b : md.b;
`ifdef MULDIV_DIV_EN
  assign w_is_div    = (md.op == MD_DIV) || (md.op == MD_DIVU);
`endif

  assign w_iter = (r_state == MUL) || (r_state == DIV);
  assign w_prod = r_neg ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi  (r_acc_hi),
    .acc_lo  (r_acc_lo),
    .operand (r_operand),
    .mode    (r_state == DIV),
    .next_hi (w_step_hi),
    .next_lo (w_step_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_nxt = MUL;
          end
`ifdef MULDIV_DIV_EN
          else if (w_is_div) begin
            w_state_nxt = DIV;
          end
`endif
        end
      end
`ifdef MULDIV_DIV_EN
      MUL, DIV: begin
`else
      MUL: begin
`endif
        w_busy = 1'b1;
        if (md.flush) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == c_last) begin
          w_state_nxt = FIX;
        end
      end
      // The op has already completed here, so flush cannot cancel it.
      FIX: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_operand <= '0;
      r_neg     <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_rem <= 1'b0;
`endif
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_acc_hi  <= '0;
        r_acc_lo  <= w_abs_b;
        r_operand <= w_abs_a;
        r_cnt     <= '0;
        r_neg     <= w_sign_a ^ w_sign_b;
`ifdef MULDIV_DIV_EN
        r_is_div  <= 1'b0;
`endif
      end
`ifdef MULDIV_DIV_EN
      else if (w_is_div) begin
        r_acc_hi  <= '0;
        r_acc_lo  <= w_abs_a;
        r_operand <= w_abs_b;
        r_cnt     <= '0;
        // Divide-by-zero keeps the all-ones quotient unsigned.
        r_neg     <= (w_sign_a ^ w_sign_b) && (md.b != '0);
        r_neg_rem <= w_sign_a;
        r_is_div  <= 1'b1;
      end
`endif
      else if (md.op == MD_MTHI) begin
        r_hi <= md.a;
      end else if (md.op == MD_MTLO) begin
        r_lo <= md.a;
      end
    end else if (w_iter) begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      if (r_cnt != c_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (w_done) begin
`ifdef MULDIV_DIV_EN
      if (r_is_div) begin
        r_lo <= r_neg ? -r_acc_lo : r_acc_lo;
        r_hi <= r_neg_rem ? -r_acc_hi : r_acc_hi;
      end else begin
        {r_hi, r_lo} <= w_prod;
      end
`else
      {r_hi, r_lo} <= w_prod;
`endif
    end
  end

  assign md.busy   = w_busy;
  assign md.done   = w_done;
  assign md.result = (md.op == MD_MFHI) ? r_hi :
                     (md.op == MD_MFLO) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Purpose  : Self-checking bench for muldiv_ctrl. Expected HI/LO values come
//            from a 64-bit arithmetic model of the mult/div/mt rules; latency
//            expectations come from the WIDTH+1 busy window.
// Config   : MULDIV_DIV_EN selects whether div/divu are expected to execute.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) md ();
  muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .md(md.slave));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          busy_cyc, done_cnt, done_at;
  logic [31:0] got_hi, got_lo;

  // ---------------- reference model ----------------
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
      MD_MULTU: begin up = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = up; end
      MD_DIV, MD_DIVU: begin
        if (DIV_EN) begin
          if (b == 32'd0) begin
            m_hi = a; m_lo = 32'hFFFF_FFFF;
          end else if (op == MD_DIV) begin
            m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
          end else begin
            m_lo = a / b; m_hi = a % b;
          end
        end
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] op);
    if (op == MD_MULT || op == MD_MULTU) return W + 1;
    if ((op == MD_DIV || op == MD_DIVU) && DIV_EN) return W + 1;
    return 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Issues one request and walks to the first non-busy cycle (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md.start = 1'b1; md.op = op; md.a = a; md.b = b;
    @(negedge clk);
    md.start = 1'b0;
    busy_cyc = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 100; k++) begin
      if (md.done) begin done_cnt++; done_at = k; end
      if (!md.busy) break;
      busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo();
    md.op = MD_MFHI; #1 got_hi = md.result;
    md.op = MD_MFLO; #1 got_lo = md.result;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", md.busy); end
    n_tests++; if (md.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", md.done); end
    read_hilo();
    n_tests++; if (got_hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", got_hi); end
    n_tests++; if (got_lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", got_lo); end
  endtask

  task automatic test_mult();
    @(negedge clk);
    md.op = MD_MULT; #1;
    n_tests++; if (md.result !== 32'h0) begin n_fail++; $display("FAIL result_non_mf: got %h want 0", md.result); end
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    model(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    n_tests++; if (busy_cyc != 33) begin n_fail++; $display("FAIL mult_busy_len: got %0d want 33", busy_cyc); end
    n_tests++; if (done_at != 33 || done_cnt != 1) begin n_fail++; $display("FAIL mult_done: got at %0d x%0d want at 33 x1", done_at, done_cnt); end
    read_hilo();
    n_tests++; if (got_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want FFFFFFFF", got_hi); end
    n_tests++; if (got_lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want FFFFFFEB", got_lo); end
  endtask

  task automatic test_multu_busy_start();
    logic [31:0] old_hi;
    int          rest;
    old_hi = m_hi;
    @(negedge clk);
    md.start = 1'b1; md.op = MD_MULTU; md.a = 32'hFFFF_FFFF; md.b = 32'hFFFF_FFFF;
    @(negedge clk);
    md.start = 1'b0;
    repeat (4) @(negedge clk);
    md.start = 1'b1; md.op = MD_MTHI; md.a = 32'hDEAD_BEEF;
    @(negedge clk);
    md.start = 1'b0; md.op = MD_MFHI; #1;
    n_tests++; if (md.result !== old_hi) begin n_fail++; $display("FAIL busy_old_hi: got %h want %h", md.result, old_hi); end
    rest = 0;
    for (int k = 0; k < 100; k++) begin
      if (!md.busy) break;
      rest++;
      @(negedge clk);
    end
    n_tests++; if (rest != 28) begin n_fail++; $display("FAIL multu_busy_rest: got %0d want 28", rest); end
    model(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_hilo();
    n_tests++; if (got_hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want FFFFFFFE", got_hi); end
    n_tests++; if (got_lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", got_lo); end
  endtask

  task automatic test_div();
    logic [2:0]  ops [3] = '{MD_DIV, MD_DIVU, MD_DIV};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i]);
      model(ops[i], as[i], bs[i]);
      n_tests++; if (busy_cyc != exp_busy(ops[i])) begin n_fail++; $display("FAIL div%0d_busy: got %0d want %0d", i, busy_cyc, exp_busy(ops[i])); end
      read_hilo();
      n_tests++; if (got_hi !== m_hi) begin n_fail++; $display("FAIL div%0d_hi: got %h want %h", i, got_hi, m_hi); end
      n_tests++; if (got_lo !== m_lo) begin n_fail++; $display("FAIL div%0d_lo: got %h want %h", i, got_lo, m_lo); end
    end
  endtask

  task automatic test_mt_mf();
    run_op(MD_MTHI, 32'h1234_5678, 32'h0);
    model(MD_MTHI, 32'h1234_5678, 32'h0);
    n_tests++; if (busy_cyc != 0 || done_cnt != 0) begin n_fail++; $display("FAIL mthi_busy: got busy %0d done %0d want 0 0", busy_cyc, done_cnt); end
    read_hilo();
    n_tests++; if (got_hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_mfhi: got %h want 12345678", got_hi); end
    run_op(MD_MTLO, 32'h0BAD_CAFE, 32'h0);
    model(MD_MTLO, 32'h0BAD_CAFE, 32'h0);
    read_hilo();
    n_tests++; if (got_lo !== 32'h0BAD_CAFE || got_hi !== m_hi) begin n_fail++; $display("FAIL mtlo: got %h/%h want %h/%h", got_hi, got_lo, m_hi, m_lo); end
  endtask

  task automatic test_flush_busy();
    logic [2:0] fop;
    int         seen_done;
    fop = DIV_EN ? MD_DIV : MD_MULT;
    seen_done = 0;
    @(negedge clk);
    md.start = 1'b1; md.op = fop; md.a = 32'd100; md.b = 32'd3;
    @(negedge clk);
    md.start = 1'b0;
    repeat (9) @(negedge clk);
    n_tests++; if (md.busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b want 1", md.busy); end
    md.flush = 1'b1;
    @(negedge clk);
    md.flush = 1'b0;
    n_tests++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_drop: got %b want 0", md.busy); end
    repeat (40) begin
      if (md.done) seen_done++;
      @(negedge clk);
    end
    n_tests++; if (seen_done != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", seen_done); end
    read_hilo();
    n_tests++; if (got_hi !== m_hi || got_lo !== m_lo) begin n_fail++; $display("FAIL flush_hilo: got %h/%h want %h/%h", got_hi, got_lo, m_hi, m_lo); end
  endtask

  task automatic test_flush_start();
    @(negedge clk);
    md.start = 1'b1; md.flush = 1'b1; md.op = MD_MTHI; md.a = 32'h0BAD_F00D;
    @(negedge clk);
    md.op = MD_MULT; md.a = 32'd9; md.b = 32'd9;
    @(negedge clk);
    md.start = 1'b0; md.flush = 1'b0;
    n_tests++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", md.busy); end
    read_hilo();
    n_tests++; if (got_hi !== m_hi) begin n_fail++; $display("FAIL flush_start_mthi: got %h want %h", got_hi, m_hi); end
  endtask

  task automatic test_flush_done();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    @(negedge clk);
    md.start = 1'b1; md.op = MD_MULTU; md.a = a; md.b = b;
    @(negedge clk);
    md.start = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 100; k++) begin
      if (md.done) begin done_at = k; break; end
      @(negedge clk);
    end
    md.flush = 1'b1;
    @(negedge clk);
    md.flush = 1'b0;
    model(MD_MULTU, a, b);
    n_tests++; if (done_at != 33) begin n_fail++; $display("FAIL flush_done_at: got %0d want 33", done_at); end
    n_tests++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL flush_done_busy: got %b want 0", md.busy); end
    read_hilo();
    n_tests++; if (got_hi !== m_hi || got_lo !== m_lo) begin n_fail++; $display("FAIL flush_done_commit: got %h/%h want %h/%h", got_hi, got_lo, m_hi, m_lo); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    md.start = 1'b1; md.op = MD_MULT; md.a = 32'h0000_1234; md.b = 32'h0000_5678;
    @(negedge clk);
    md.start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_tests++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", md.busy); end
    md.op = MD_MFHI; #1;
    n_tests++; if (md.result !== 32'h0) begin n_fail++; $display("FAIL arst_hi: got %h want 0", md.result); end
    md.op = MD_MFLO; #1;
    n_tests++; if (md.result !== 32'h0) begin n_fail++; $display("FAIL arst_lo: got %h want 0", md.result); end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(MD_MULT, 32'd5, 32'hFFFF_FFFE);
    model(MD_MULT, 32'd5, 32'hFFFF_FFFE);
    n_tests++; if (busy_cyc != 33) begin n_fail++; $display("FAIL arst_restart_busy: got %0d want 33", busy_cyc); end
    read_hilo();
    n_tests++; if (got_hi !== m_hi || got_lo !== m_lo) begin n_fail++; $display("FAIL arst_restart_hilo: got %h/%h want %h/%h", got_hi, got_lo, m_hi, m_lo); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op(op, a, b);
      model(op, a, b);
      n_tests++; if (busy_cyc != exp_busy(op)) begin n_fail++; $display("FAIL rnd%0d_busy: op %0d got %0d want %0d", i, op, busy_cyc, exp_busy(op)); end
      n_tests++; if (done_cnt != ((exp_busy(op) != 0) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_done: op %0d got %0d pulses", i, op, done_cnt); end
      read_hilo();
      n_tests++; if (got_hi !== m_hi) begin n_fail++; $display("FAIL rnd%0d_hi: op %0d a %h b %h got %h want %h", i, op, a, b, got_hi, m_hi); end
      n_tests++; if (got_lo !== m_lo) begin n_fail++; $display("FAIL rnd%0d_lo: op %0d a %h b %h got %h want %h", i, op, a, b, got_lo, m_lo); end
    end
  endtask

  initial begin
    md.start = 1'b0;
    md.flush = 1'b0;
    md.op    = MD_MFHI;
    md.a     = '0;
    md.b     = '0;
    test_reset();
    test_mult();
    test_multu_busy_start();
    test_div();
    test_mt_mf();
    test_flush_busy();
    test_flush_start();
    test_flush_done();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
